// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of Datamem: accept -> EXEC (drive memory) -> RESP (return result).
// Define DATAMEM_ARB_RR_EN for round-robin arbitration instead of fixed priority plus starvation counter.
module datamem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_write,
    input  logic [31:0] p0_address,
    input  logic [2:0]  p0_rflags,
    input  logic [1:0]  p0_wflags,
    input  logic [31:0] p0_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_data,
    output logic        p0_rsp_err,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_write,
    input  logic [31:0] p1_address,
    input  logic [2:0]  p1_rflags,
    input  logic [1:0]  p1_wflags,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_data,
    output logic        p1_rsp_err,
    output logic [31:0] mem_address,
    output logic [2:0]  mem_rflags,
    output logic [1:0]  mem_wflags,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_value
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t            r_state;
    logic              r_port;
    logic              r_write;
    logic              r_err;
    logic [WAIT_W-1:0] r_wait;
`ifdef DATAMEM_ARB_RR_EN
    logic              r_last;
`endif

    logic        w_idle;
    logic        w_grant1;
    logic        w_accept;
    logic        w_write;
    logic        w_err;
    logic [31:0] w_address;
    logic [31:0] w_wdata;
    logic [2:0]  w_rflags;
    logic [1:0]  w_wflags;
    logic [31:0] w_rsp_data;

    // Ready is gated by reset so nothing looks accepted while the block is held in reset.
    assign w_idle = reset && (r_state == IDLE);

    always_comb begin
        w_grant1 = 1'b0;
`ifdef DATAMEM_ARB_RR_EN
        if (p0_valid && p1_valid)
            w_grant1 = ~r_last;
        else
            w_grant1 = p1_valid;
`else
        if (p1_valid && (r_wait == WAIT_W'(MAX_WAIT)))
            w_grant1 = 1'b1;
        else if (p0_valid)
            w_grant1 = 1'b0;
        else
            w_grant1 = p1_valid;
`endif
    end

    assign p0_ready = w_idle && p0_valid && !w_grant1;
    assign p1_ready = w_idle && p1_valid && w_grant1;
    assign w_accept = p0_ready || p1_ready;

    assign w_write   = w_grant1 ? p1_write   : p0_write;
    assign w_address = w_grant1 ? p1_address : p0_address;
    assign w_rflags  = w_grant1 ? p1_rflags  : p0_rflags;
    assign w_wflags  = w_grant1 ? p1_wflags  : p0_wflags;
    assign w_wdata   = w_grant1 ? p1_wdata   : p0_wdata;

    assign w_err = w_write ? (w_wflags == 2'd3)
                           : ((w_rflags == 3'd3) || (w_rflags == 3'd6) || (w_rflags == 3'd7));

    assign w_rsp_data = (!r_write && !r_err) ? mem_value : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_wait       <= '0;
`ifdef DATAMEM_ARB_RR_EN
            r_last       <= 1'b1;
`endif
            p0_rsp_valid <= 1'b0;
            p0_rsp_data  <= 32'd0;
            p0_rsp_err   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_data  <= 32'd0;
            p1_rsp_err   <= 1'b0;
            mem_address  <= 32'd0;
            mem_rflags   <= 3'd0;
            mem_wflags   <= 2'd0;
            mem_wdata    <= 32'd0;
            mem_we       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
`ifdef DATAMEM_ARB_RR_EN
                    if (w_accept)
                        r_last <= w_grant1;
`else
                    if (p1_ready)
                        r_wait <= '0;
                    else if (p1_valid && (r_wait != WAIT_W'(MAX_WAIT)))
                        r_wait <= r_wait + 1'b1;
`endif
                    if (w_accept) begin
                        r_port      <= w_grant1;
                        r_write     <= w_write;
                        r_err       <= w_err;
                        mem_address <= w_address;
                        mem_rflags  <= w_rflags;
                        mem_wflags  <= w_wflags;
                        mem_wdata   <= w_wdata;
                        mem_we      <= w_write && !w_err;
                        r_state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_port) begin
                        p1_rsp_valid <= 1'b1;
                        p1_rsp_data  <= w_rsp_data;
                        p1_rsp_err   <= r_err;
                    end else begin
                        p0_rsp_valid <= 1'b1;
                        p0_rsp_data  <= w_rsp_data;
                        p0_rsp_err   <= r_err;
                    end
                    // mem_rflags is left latched so the combinational read stays defined.
                    mem_address <= 32'd0;
                    mem_wflags  <= 2'd0;
                    mem_wdata   <= 32'd0;
                    mem_we      <= 1'b0;
                    r_state     <= RESP;
                end
                RESP: begin
                    p0_rsp_valid <= 1'b0;
                    p0_rsp_data  <= 32'd0;
                    p0_rsp_err   <= 1'b0;
                    p1_rsp_valid <= 1'b0;
                    p1_rsp_data  <= 32'd0;
                    p1_rsp_err   <= 1'b0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a small byte-addressed Datamem model.
`timescale 1ns/1ps
module tb_datamem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        p0_valid, p0_ready, p0_write, p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_address, p0_wdata, p0_rsp_data;
    logic [2:0]  p0_rflags;
    logic [1:0]  p0_wflags;
    logic        p1_valid, p1_ready, p1_write, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_address, p1_wdata, p1_rsp_data;
    logic [2:0]  p1_rflags;
    logic [1:0]  p1_wflags;
    logic [31:0] mem_address, mem_wdata, mem_value;
    logic [2:0]  mem_rflags;
    logic [1:0]  mem_wflags;
    logic        mem_we;

    datamem_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .clock(clock), .reset(reset),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write),
        .p0_address(p0_address), .p0_rflags(p0_rflags), .p0_wflags(p0_wflags),
        .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p0_rsp_err(p0_rsp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write),
        .p1_address(p1_address), .p1_rflags(p1_rflags), .p1_wflags(p1_wflags),
        .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .p1_rsp_err(p1_rsp_err),
        .mem_address(mem_address), .mem_rflags(mem_rflags), .mem_wflags(mem_wflags),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_value(mem_value)
    );

    always #5 clock = ~clock;

    // Datamem model: synchronous write, combinational sign/zero-extending read, little-endian.
    logic [7:0] dm [0:255] = '{default: 8'h00};
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    assign a0 = mem_address[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;
    assign b0 = dm[a0];
    assign b1 = dm[a1];
    assign b2 = dm[a2];
    assign b3 = dm[a3];

    always_comb begin
        case (mem_rflags)
            3'd0:    mem_value = {{24{b0[7]}}, b0};
            3'd1:    mem_value = {{16{b1[7]}}, b1, b0};
            3'd2:    mem_value = {b3, b2, b1, b0};
            3'd4:    mem_value = {24'd0, b0};
            3'd5:    mem_value = {16'd0, b1, b0};
            default: mem_value = 32'd0;
        endcase
    end

    always @(posedge clock) begin
        if (mem_we) begin
            case (mem_wflags)
                2'd0: dm[a0] <= mem_wdata[7:0];
                2'd1: begin
                    dm[a0] <= mem_wdata[7:0];
                    dm[a1] <= mem_wdata[15:8];
                end
                2'd2: begin
                    dm[a0] <= mem_wdata[7:0];
                    dm[a1] <= mem_wdata[15:8];
                    dm[a2] <= mem_wdata[23:16];
                    dm[a3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    int we_cnt = 0, rsp0_cnt = 0, rsp1_cnt = 0;
    int glog[$];
    always @(posedge clock) begin
        if (mem_we) we_cnt <= we_cnt + 1;
        if (p0_rsp_valid) rsp0_cnt <= rsp0_cnt + 1;
        if (p1_rsp_valid) rsp1_cnt <= rsp1_cnt + 1;
        if (p0_valid && p0_ready) glog.push_back(0);
        if (p1_valid && p1_ready) glog.push_back(1);
    end

    int checks = 0, errors = 0;

    logic        s1_we, s1_rsp, s2_rv0, s2_rv1, s2_err0, s2_err1, s3_rv;
    logic [1:0]  s1_wflags;
    logic [31:0] s1_addr, s1_wdata, s2_d0, s2_d1;
    int          s_we_ops;

    task automatic idle_inputs();
        p0_valid = 0; p0_write = 0; p0_address = 0; p0_rflags = 0; p0_wflags = 0; p0_wdata = 0;
        p1_valid = 0; p1_write = 0; p1_address = 0; p1_rflags = 0; p1_wflags = 0; p1_wdata = 0;
    endtask

    // Issues one op on a single port and snapshots the outputs 1, 2 and 3 cycles after acceptance.
    task automatic run_op(input bit port, input logic w, input logic [31:0] a,
                          input logic [2:0] rf, input logic [1:0] wf, input logic [31:0] wd);
        int n;
        int we0;
        @(negedge clock);
        if (port) begin
            p1_valid = 1; p1_write = w; p1_address = a; p1_rflags = rf; p1_wflags = wf; p1_wdata = wd;
        end else begin
            p0_valid = 1; p0_write = w; p0_address = a; p0_rflags = rf; p0_wflags = wf; p0_wdata = wd;
        end
        #1;
        n = 0;
        while (!(port ? p1_ready : p0_ready) && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL ready_timeout port=%0d: got no ready in 20 cycles, required ready", port);
        end
        we0 = we_cnt;
        @(negedge clock);
        p0_valid = 0;
        p1_valid = 0;
        s1_we = mem_we; s1_wflags = mem_wflags; s1_addr = mem_address; s1_wdata = mem_wdata;
        s1_rsp = p0_rsp_valid | p1_rsp_valid;
        @(negedge clock);
        s2_rv0 = p0_rsp_valid; s2_rv1 = p1_rsp_valid; s2_d0 = p0_rsp_data; s2_d1 = p1_rsp_data;
        s2_err0 = p0_rsp_err; s2_err1 = p1_rsp_err;
        @(negedge clock);
        s3_rv = p0_rsp_valid | p1_rsp_valid;
        s_we_ops = we_cnt - we0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        p0_valid = 1;
        p1_valid = 1;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({p0_ready, p1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b, required 00", {p0_ready, p1_ready});
        end
        checks++;
        if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, mem_we} !== 5'd0) begin
            errors++; $display("FAIL reset_flags: got %b, required 00000",
                               {p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, mem_we});
        end
        checks++;
        if ({p0_rsp_data, p1_rsp_data, mem_address, mem_wdata} !== 128'd0) begin
            errors++; $display("FAIL reset_data: got %h, required 0",
                               {p0_rsp_data, p1_rsp_data, mem_address, mem_wdata});
        end
        checks++;
        if ({mem_rflags, mem_wflags} !== 5'd0) begin
            errors++; $display("FAIL reset_mflags: got %b, required 00000", {mem_rflags, mem_wflags});
        end
        idle_inputs();
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_store_load();
        run_op(0, 1'b1, 32'h10, 3'd2, 2'd2, 32'hDEADBEEF);
        checks++;
        if (s1_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b, required 1", s1_we); end
        checks++;
        if (s1_wflags !== 2'd2) begin errors++; $display("FAIL sw_wflags: got %0d, required 2", s1_wflags); end
        checks++;
        if (s1_addr !== 32'h10) begin errors++; $display("FAIL sw_addr: got %h, required 00000010", s1_addr); end
        checks++;
        if (s1_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h, required deadbeef", s1_wdata); end
        checks++;
        if (s1_rsp !== 1'b0) begin errors++; $display("FAIL sw_early_rsp: got %b, required 0", s1_rsp); end
        checks++;
        if ({s2_rv0, s2_rv1} !== 2'b10) begin errors++; $display("FAIL sw_rsp_port: got %b, required 10", {s2_rv0, s2_rv1}); end
        checks++;
        if (s2_d0 !== 32'd0) begin errors++; $display("FAIL sw_rsp_data: got %h, required 0", s2_d0); end
        checks++;
        if (s_we_ops !== 1) begin errors++; $display("FAIL sw_we_cycles: got %0d, required 1", s_we_ops); end
        checks++;
        if (s3_rv !== 1'b0) begin errors++; $display("FAIL sw_rsp_len: got %b, required 0", s3_rv); end
        checks++;
        if ({dm[8'h13], dm[8'h12], dm[8'h11], dm[8'h10]} !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_mem: got %h, required deadbeef", {dm[8'h13], dm[8'h12], dm[8'h11], dm[8'h10]});
        end

        run_op(0, 1'b0, 32'h10, 3'd2, 2'd0, 32'd0);
        checks++;
        if (s1_we !== 1'b0) begin errors++; $display("FAIL lw_we: got %b, required 0", s1_we); end
        checks++;
        if ({s2_rv0, s2_rv1} !== 2'b10) begin errors++; $display("FAIL lw_rsp_port: got %b, required 10", {s2_rv0, s2_rv1}); end
        checks++;
        if (s2_d0 !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h, required deadbeef", s2_d0); end
        checks++;
        if (s2_err0 !== 1'b0) begin errors++; $display("FAIL lw_err: got %b, required 0", s2_err0); end
    endtask

    task automatic test_byte_loads();
        run_op(0, 1'b1, 32'h10, 3'd0, 2'd0, 32'h0000_0080);
        checks++;
        if ({dm[8'h11], dm[8'h10]} !== 16'hBE80) begin
            errors++; $display("FAIL sb_mem: got %h, required be80", {dm[8'h11], dm[8'h10]});
        end
        run_op(0, 1'b0, 32'h10, 3'd0, 2'd0, 32'd0);
        checks++;
        if (s2_d0 !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h, required ffffff80", s2_d0); end
        run_op(0, 1'b0, 32'h10, 3'd4, 2'd0, 32'd0);
        checks++;
        if (s2_d0 !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h, required 00000080", s2_d0); end
        run_op(0, 1'b0, 32'h10, 3'd1, 2'd0, 32'd0);
        checks++;
        if (s2_d0 !== 32'hFFFFBE80) begin errors++; $display("FAIL lh_data: got %h, required ffffbe80", s2_d0); end
        run_op(0, 1'b0, 32'h10, 3'd5, 2'd0, 32'd0);
        checks++;
        if (s2_d0 !== 32'h0000BE80) begin errors++; $display("FAIL lhu_data: got %h, required 0000be80", s2_d0); end
    endtask

    task automatic test_port1_errors();
        run_op(1, 1'b0, 32'h10, 3'd2, 2'd0, 32'd0);
        checks++;
        if ({s2_rv0, s2_rv1} !== 2'b01) begin errors++; $display("FAIL p1_rsp_port: got %b, required 01", {s2_rv0, s2_rv1}); end
        checks++;
        if (s2_d1 !== 32'hDEADBE80) begin errors++; $display("FAIL p1_lw_data: got %h, required deadbe80", s2_d1); end

        run_op(0, 1'b0, 32'h10, 3'd3, 2'd0, 32'd0);
        checks++;
        if ({s2_err0, s2_d0} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL bad_load: got err=%b data=%h, required err=1 data=0", s2_err0, s2_d0);
        end

        run_op(1, 1'b1, 32'h20, 3'd2, 2'd3, 32'h12345678);
        checks++;
        if ({s1_we, s_we_ops != 0} !== 2'b00) begin
            errors++; $display("FAIL bad_store_we: got we=%b cycles=%0d, required 0", s1_we, s_we_ops);
        end
        checks++;
        if ({s2_rv0, s2_rv1} !== 2'b01) begin errors++; $display("FAIL bad_store_port: got %b, required 01", {s2_rv0, s2_rv1}); end
        checks++;
        if (s2_err1 !== 1'b1) begin errors++; $display("FAIL bad_store_err: got %b, required 1", s2_err1); end
        checks++;
        if (s2_d1 !== 32'd0) begin errors++; $display("FAIL bad_store_data: got %h, required 0", s2_d1); end
        checks++;
        if ({dm[8'h23], dm[8'h22], dm[8'h21], dm[8'h20]} !== 32'd0) begin
            errors++; $display("FAIL bad_store_mem: got %h, required 0", {dm[8'h23], dm[8'h22], dm[8'h21], dm[8'h20]});
        end
    endtask

    task automatic test_contention();
        int g0, r0a, r1a, got, want, w0, w1;
        g0 = glog.size(); r0a = rsp0_cnt; r1a = rsp1_cnt;
        @(negedge clock);
        p0_valid = 1; p0_write = 0; p0_address = 32'h10; p0_rflags = 3'd2; p0_wflags = 2'd0;
        p1_valid = 1; p1_write = 0; p1_address = 32'h10; p1_rflags = 3'd2; p1_wflags = 2'd0;
        repeat (30) @(posedge clock);
        @(negedge clock);
        p0_valid = 0;
        p1_valid = 0;
        repeat (3) @(negedge clock);
        checks++;
        if (glog.size() - g0 !== 10) begin
            errors++; $display("FAIL cont_grants: got %0d, required 10", glog.size() - g0);
        end
        for (int i = 0; i < 10; i++) begin
`ifdef DATAMEM_ARB_RR_EN
            want = i % 2;
`else
            want = ((i % 5) == 4) ? 1 : 0;
`endif
            got = (g0 + i < glog.size()) ? glog[g0 + i] : -1;
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL cont_order[%0d]: got port %0d, required port %0d", i, got, want);
            end
        end
`ifdef DATAMEM_ARB_RR_EN
        w0 = 5; w1 = 5;
`else
        w0 = 8; w1 = 2;
`endif
        checks++;
        if ({rsp0_cnt - r0a, rsp1_cnt - r1a} !== {w0, w1}) begin
            errors++; $display("FAIL cont_rsp: got p0=%0d p1=%0d, required p0=%0d p1=%0d",
                               rsp0_cnt - r0a, rsp1_cnt - r1a, w0, w1);
        end
    endtask

    task automatic test_reset_midop();
        int r0a, r1a;
        r0a = rsp0_cnt; r1a = rsp1_cnt;
        @(negedge clock);
        p0_valid = 1; p0_write = 1; p0_address = 32'h30; p0_rflags = 3'd2; p0_wflags = 2'd2;
        p0_wdata = 32'hCAFEF00D;
        @(negedge clock);
        p0_valid = 0;
        checks++;
        if (mem_we !== 1'b1) begin errors++; $display("FAIL midop_exec_we: got %b, required 1", mem_we); end
        reset = 0;
        #1;
        checks++;
        if ({mem_we, p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err} !== 7'd0) begin
            errors++; $display("FAIL midop_reset_ctl: got %b, required 0",
                {mem_we, p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err});
        end
        checks++;
        if ({mem_address, mem_wdata, mem_rflags, mem_wflags, p0_rsp_data, p1_rsp_data} !== 133'd0) begin
            errors++; $display("FAIL midop_reset_data: got %h, required 0",
                {mem_address, mem_wdata, mem_rflags, mem_wflags, p0_rsp_data, p1_rsp_data});
        end
        repeat (2) @(negedge clock);
        reset = 1;
        repeat (4) @(negedge clock);
        checks++;
        if ({rsp0_cnt - r0a, rsp1_cnt - r1a} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL midop_no_rsp: got p0=%0d p1=%0d, required 0", rsp0_cnt - r0a, rsp1_cnt - r1a);
        end
        checks++;
        if ({dm[8'h33], dm[8'h32], dm[8'h31], dm[8'h30]} !== 32'd0) begin
            errors++; $display("FAIL midop_mem: got %h, required 0", {dm[8'h33], dm[8'h32], dm[8'h31], dm[8'h30]});
        end
        run_op(0, 1'b0, 32'h10, 3'd2, 2'd0, 32'd0);
        checks++;
        if ({s2_rv0, s2_d0} !== {1'b1, 32'hDEADBE80}) begin
            errors++; $display("FAIL after_reset_lw: got v=%b data=%h, required v=1 data=deadbe80", s2_rv0, s2_d0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte_loads();
        test_port1_errors();
        test_contention();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
